// File: rtl/ext_div_unit_pkg.sv
// Shared definitions for the external-execute divider: op encodings, FSM states
// and small sign helpers used by the top-level fix-up logic.
package ext_div_unit_pkg;

  localparam int XLEN       = 32;
  localparam int OP_W       = 10;
  localparam int EXT_EN_BIT = 9;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    EXT_OP_DIV  = 2'd0,
    EXT_OP_DIVU = 2'd1,
    EXT_OP_REM  = 2'd2,
    EXT_OP_REMU = 2'd3
  } ext_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Per-request decode, captured in IDLE.
  typedef struct packed {
    logic is_signed;
    logic is_rem;
    logic neg_q;
    logic neg_r;
  } div_ctl_t;

  function automatic logic op_is_signed(input logic [1:0] sel);
    return (sel == EXT_OP_DIV) || (sel == EXT_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] sel);
    return (sel == EXT_OP_REM) || (sel == EXT_OP_REMU);
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/ext_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor when it fits. Purely combinational.
module div_step
  import ext_div_unit_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  // One extra bit keeps the compare exact even if the partial remainder has its MSB set.
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       unused_diff_msb;

  assign shifted         = {rem_i, dvd_msb_i};
  assign diff            = shifted - {1'b0, divisor_i};
  assign q_bit_o         = (shifted >= {1'b0, divisor_i});
  assign rem_o           = q_bit_o ? diff[W-1:0] : shifted[W-1:0];
  assign unused_diff_msb = diff[W];

endmodule

// File: rtl/ext_div_unit.sv
// RV32M DIV/DIVU/REM/REMU responder on the external-execute port. Radix-2
// restoring divider, one quotient bit per cycle, with fast paths for x/0 and overflow.
module ext_div_unit
  import ext_div_unit_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int OP_W_P = OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_ex_en,
  input  logic [XLEN_P-1:0] ext_ex_a,
  input  logic [XLEN_P-1:0] ext_ex_b,
  input  logic [XLEN_P-1:0] ext_ex_c,
  input  logic [OP_W_P-1:0] ext_ex_operation,
  output logic              ext_ex_bussy,
  output logic [XLEN_P-1:0] ext_ex_y
);

  localparam logic [XLEN_P-1:0] MIN_NEG = {1'b1, {(XLEN_P-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN_P-1:0] dvd_q, dsr_q, rem_q, quo_q, y_q;
  div_ctl_t          ctl_q;

  div_ctl_t          req_ctl;
  logic [XLEN_P-1:0] a_mag, b_mag, fast_y;
  logic              req_div0, req_ovf, req_fast;

  logic [XLEN_P-1:0] step_rem, quo_next, final_y;
  logic              step_qbit;
  logic              unused_ins;

  assign unused_ins = ^{ext_ex_c, ext_ex_operation[OP_W_P-1:2]};

  // Request decode, only meaningful while IDLE.
  always_comb begin
    req_ctl.is_signed = op_is_signed(ext_ex_operation[1:0]);
    req_ctl.is_rem    = op_is_rem(ext_ex_operation[1:0]);
    req_ctl.neg_q     = req_ctl.is_signed & (ext_ex_a[XLEN_P-1] ^ ext_ex_b[XLEN_P-1]);
    req_ctl.neg_r     = req_ctl.is_signed & ext_ex_a[XLEN_P-1];
    a_mag    = cond_neg(ext_ex_a, req_ctl.is_signed & ext_ex_a[XLEN_P-1]);
    b_mag    = cond_neg(ext_ex_b, req_ctl.is_signed & ext_ex_b[XLEN_P-1]);
    req_div0 = (ext_ex_b == '0);
    req_ovf  = req_ctl.is_signed && (ext_ex_a == MIN_NEG) && (ext_ex_b == '1);
    req_fast = req_div0 | req_ovf;
    if (req_div0)
      fast_y = req_ctl.is_rem ? ext_ex_a : '1;
    else
      fast_y = req_ctl.is_rem ? '0 : MIN_NEG;
  end

  div_step #(.W(XLEN_P)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[XLEN_P-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  assign quo_next = {quo_q[XLEN_P-2:0], step_qbit};
  assign final_y  = ctl_q.is_rem ? cond_neg(step_rem, ctl_q.neg_r)
                                 : cond_neg(quo_next, ctl_q.neg_q);

  // The core samples bussy in the same cycle the request appears, so it is combinational.
  assign ext_ex_bussy = rst_n & ext_ex_en & (state_q != ST_DONE);
  assign ext_ex_y     = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      ctl_q   <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ext_ex_en) begin
            dvd_q <= a_mag;
            dsr_q <= b_mag;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            ctl_q <= req_ctl;
            if (req_fast) begin
              y_q     <= fast_y;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (!ext_ex_en) begin
            state_q <= ST_IDLE;
          end else begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[XLEN_P-2:0], 1'b0};
            quo_q <= quo_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
              y_q     <= final_y;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_div_unit.sv
// Scoreboard bench for ext_div_unit: driver queues expected results, a negedge
// monitor checks y whenever the unit presents a result (en && !bussy).
module tb_ext_div_unit;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic [9:0]  op = '0;
  logic        bussy;
  logic [31:0] y;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  ext_div_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ext_ex_en        (en),
    .ext_ex_a         (a),
    .ext_ex_b         (b),
    .ext_ex_c         (c),
    .ext_ex_operation (op),
    .ext_ex_bussy     (bussy),
    .ext_ex_y         (y)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && en && !bussy) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL y_unexpected: got %h with no result pending", y);
      end else begin
        mon_exp = exp_q.pop_front();
        if (y !== mon_exp) begin
          n_fail++;
          $display("FAIL y_result: got %h expected %h", y, mon_exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_y(input logic [1:0] sel, input logic [31:0] x, input logic [31:0] d);
    logic [31:0] r;
    if (d == 32'd0)
      r = sel[1] ? x : 32'hFFFF_FFFF;
    else if (!sel[0] && x == 32'h8000_0000 && d == 32'hFFFF_FFFF)
      r = sel[1] ? 32'd0 : 32'h8000_0000;
    else if (!sel[0] && sel[1])
      r = $signed(x) % $signed(d);
    else if (!sel[0])
      r = $signed(x) / $signed(d);
    else if (sel[1])
      r = x % d;
    else
      r = x / d;
    return r;
  endfunction

  // Called just after a rising edge; leaves en high so back-to-back ops can follow.
  task automatic run_op(input logic [1:0] sel, input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] exp_y, input int exp_busy, input bit wiggle);
    logic [7:0] junk;
    int cyc;
    junk = 8'($urandom_range(0, 255));
    op = {junk, sel};
    a  = da;
    b  = db;
    c  = $urandom;
    en = 1'b1;
    exp_q.push_back(exp_y);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!bussy) break;
      cyc++;
      if (wiggle && cyc == 3) begin
        a = $urandom;
        b = $urandom;
      end
      if (cyc > 100) begin
        $display("FAIL op_timeout: bussy still high after %0d cycles", cyc);
        n_fail++;
        break;
      end
    end
    check("busy_cycles", cyc, exp_busy);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_bussy", {31'd0, bussy}, 32'd0);
    check("rst_y", y, 32'd0);
    en = 1'b1; #1;
    check("rst_bussy_en", {31'd0, bussy}, 32'd0);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(DIVU, 32'd100, 32'd7, 32'd14, 33, 0);              idle(1);
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0); idle(1);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0); idle(1);
    run_op(REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 33, 0);         idle(1);
    run_op(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);          idle(1);
    run_op(REM,  32'd5, 32'd0, 32'd5, 1, 0);                  idle(1);
    run_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);          idle(1);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0); idle(1);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);  idle(1);
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0); idle(1);
    run_op(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0); idle(1);
    run_op(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);         idle(1);
    run_op(DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 33, 0); idle(1);
    run_op(DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 33, 0); idle(1);
    run_op(DIVU, 32'hFFFF_FFFF, 32'hC000_0000, 32'd1, 33, 0); idle(1);
    run_op(REMU, 32'hFFFF_FFFF, 32'hC000_0000, 32'h3FFF_FFFF, 33, 0); idle(1);
    run_op(REMU, 32'h1234_5678, 32'h100, 32'h78, 33, 0);      idle(1);
    run_op(DIVU, 32'd3, 32'd5, 32'd0, 33, 0);                 idle(1);

    // Back-to-back with identical operands: en never drops.
    run_op(DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op(DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    idle(1);

    // Operands scrambled mid-BUSY must not affect the result.
    run_op(DIVU, 32'd1000, 32'd10, 32'd100, 33, 1); idle(1);

    // Reset at BUSY count 10.
    op = {8'd0, DIVU}; a = 32'd100; b = 32'd7; en = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_bussy", {31'd0, bussy}, 32'd0);
    check("midrst_y", y, 32'd0);
    en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0); idle(1);

    // Flush mid-BUSY, then a fresh op must take the full latency.
    op = {8'd0, DIVU}; a = 32'd50; b = 32'd3; en = 1'b1;
    repeat (6) @(posedge clk);
    #1 en = 1'b0;
    #1;
    check("flush_bussy", {31'd0, bussy}, 32'd0);
    @(posedge clk); #1;
    run_op(REMU, 32'd50, 32'd3, 32'd2, 33, 0); idle(1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  s;
      logic [31:0] ra, rb;
      int          lat;
      s  = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 3 == 1) rb = {1'b1, 31'($urandom_range(0, 15))};
      if (i % 7 == 0) rb = 32'd0;
      if (i % 11 == 5) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      lat = (rb == 32'd0 || (!s[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33;
      run_op(s, ra, rb, ref_y(s, ra, rb), lat, 0);
      if (i % 2 == 0) idle(1);
    end
    idle(2);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
